// File: rtl/dmem_resp_pkg.sv
// Shared definitions for the dmem_resp data-memory responder.
// Contents: the controller state enum, the legal size-mask constants,
// the default base address and word count, and a helper that turns
// a size mask into a byte count.
package dmem_resp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_W0,
        ST_W1,
        ST_RESP,
        ST_ERR
    } state_t;

    localparam logic [7:0]  SIZE_B = 8'h01;
    localparam logic [7:0]  SIZE_H = 8'h03;
    localparam logic [7:0]  SIZE_W = 8'h0F;
    localparam logic [7:0]  SIZE_D = 8'hFF;

    localparam logic [63:0] DEF_BASE_ADDR  = 64'h8000_0000;
    localparam int          DEF_DEPTH_LOG2 = 12;

    // Byte count for a legal size mask; 0 marks an illegal mask.
    function automatic logic [3:0] size_bytes(input logic [7:0] mask);
        case (mask)
            SIZE_B:  size_bytes = 4'd1;
            SIZE_H:  size_bytes = 4'd2;
            SIZE_W:  size_bytes = 4'd4;
            SIZE_D:  size_bytes = 4'd8;
            default: size_bytes = 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_resp_if.sv
// Request/response bundle between a requester (master) and dmem_resp (slave).
//   acs_en/acs_wr/acs_bytes/acs_addr/acs_wdata : request, held until acs_ready
//   acs_rdata/acs_ready/acs_err                : one-cycle response
interface dmem_resp_if;
    logic        acs_en;
    logic        acs_wr;
    logic [7:0]  acs_bytes;
    logic [63:0] acs_addr;
    logic [63:0] acs_wdata;
    logic [63:0] acs_rdata;
    logic        acs_ready;
    logic        acs_err;

    modport master (
        output acs_en, acs_wr, acs_bytes, acs_addr, acs_wdata,
        input  acs_rdata, acs_ready, acs_err
    );

    modport slave (
        input  acs_en, acs_wr, acs_bytes, acs_addr, acs_wdata,
        output acs_rdata, acs_ready, acs_err
    );
endinterface

// File: rtl/dmem_ram.sv
// Single-port synchronous RAM, 64-bit words with 8 byte enables.
//   clk   : clock
//   en    : read enable; rdata updates one cycle later
//   we    : per-byte write enables
//   addr  : word address
//   wdata : write data
//   rdata : registered read data (not reset)
// Each byte lane is its own array so byte writes never need a
// read-modify-write.
module dmem_ram #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              en,
    input  logic [7:0]        we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [63:0]       wdata,
    output logic [63:0]       rdata
);

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_lane
            logic [7:0] lane_mem [2**ADDR_W];
            logic [7:0] lane_q;

            always_ff @(posedge clk) begin
                if (we[gi]) begin
                    lane_mem[addr] <= wdata[gi*8 +: 8];
                end
                if (en) begin
                    lane_q <= lane_mem[addr];
                end
            end

            assign rdata[gi*8 +: 8] = lane_q;
        end
    endgenerate

endmodule

// File: rtl/dmem_resp.sv
// Byte-addressed data memory responder.
//   clk : clock          rst : synchronous active-high reset
//   acs : dmem_resp_if.slave request/response bundle
// Accepts one load/store of 1/2/4/8 bytes at any alignment. Accesses
// that straddle a word boundary take two RAM cycles. Range and size
// faults are reported with acs_err and never touch memory.
module dmem_resp
    import dmem_resp_pkg::*;
#(
    parameter int          DEPTH_LOG2 = DEF_DEPTH_LOG2,
    parameter logic [63:0] BASE_ADDR  = DEF_BASE_ADDR
) (
    input  logic        clk,
    input  logic        rst,
    dmem_resp_if.slave  acs
);

    state_t                state_reg, state_next;
    logic                  wr_reg;
    logic [7:0]            bytes_reg;
    logic [63:0]           addr_reg;
    logic [63:0]           wdata_reg;
    logic [63:0]           word0_reg;

    logic [3:0]            n_bytes;
    logic [2:0]            offset;
    logic                  crossing;
    logic                  access_err;
    logic [64:0]           last_byte;
    logic [64:0]           limit;
    logic [DEPTH_LOG2-1:0] word0_idx;
    logic [DEPTH_LOG2-1:0] word1_idx;
    logic [7:0]            be0, be1;
    logic [63:0]           data0, data1;
    logic [63:0]           lo_word, hi_word;
    logic [63:0]           load_mask;
    logic [63:0]           load_data;

    logic                  ram_en;
    logic [7:0]            ram_we;
    logic [DEPTH_LOG2-1:0] ram_addr;
    logic [63:0]           ram_wdata;
    logic [63:0]           ram_rdata;

    assign n_bytes  = size_bytes(bytes_reg);
    assign offset   = addr_reg[2:0];
    assign crossing = ({1'b0, offset} + n_bytes) > 4'd8;

    // 65-bit arithmetic so the end-of-memory test cannot wrap.
    assign last_byte  = {1'b0, addr_reg} + 65'(n_bytes) - 65'd1;
    assign limit      = {1'b0, BASE_ADDR} + (65'd8 << DEPTH_LOG2);
    assign access_err = (n_bytes == 4'd0)
                     || ({1'b0, addr_reg} < {1'b0, BASE_ADDR})
                     || (last_byte >= limit);

    assign word0_idx = DEPTH_LOG2'((addr_reg - BASE_ADDR) >> 3);
    assign word1_idx = word0_idx + DEPTH_LOG2'(1);

    // Store lanes: shift mask and data as one 2-word window.
    assign {be1, be0}     = 16'({8'h00, bytes_reg} << offset);
    assign {data1, data0} = 128'({64'h0, wdata_reg} << {offset, 3'b000});

    // Load assembly: in RESP the RAM holds the last word read; for a
    // crossing load that is the second word and the first was captured.
    assign lo_word = crossing ? word0_reg : ram_rdata;
    assign hi_word = crossing ? ram_rdata : 64'h0;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_mask
            assign load_mask[gi*8 +: 8] = {8{bytes_reg[gi]}};
        end
    endgenerate

    assign load_data = 64'({hi_word, lo_word} >> {offset, 3'b000}) & load_mask;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            wr_reg    <= 1'b0;
            bytes_reg <= 8'h00;
            addr_reg  <= 64'h0;
            wdata_reg <= 64'h0;
            word0_reg <= 64'h0;
        end else begin
            state_reg <= state_next;
            if (state_reg == ST_IDLE && acs.acs_en) begin
                wr_reg    <= acs.acs_wr;
                bytes_reg <= acs.acs_bytes;
                addr_reg  <= acs.acs_addr;
                wdata_reg <= acs.acs_wdata;
            end
            if (state_reg == ST_W1) begin
                word0_reg <= ram_rdata;
            end
        end
    end

    // Writes issued before the response are gated by rst so a reset
    // abandons the access. A crossing store commits word 0 in W1 and
    // word 1 in RESP, so a reset before the pulse prevents both.
    always_comb begin
        state_next    = state_reg;
        ram_en        = 1'b0;
        ram_we        = 8'h00;
        ram_addr      = word0_idx;
        ram_wdata     = data0;
        acs.acs_ready = 1'b0;
        acs.acs_err   = 1'b0;
        acs.acs_rdata = 64'h0;

        case (state_reg)
            ST_IDLE: begin
                if (acs.acs_en) begin
                    state_next = ST_W0;
                end
            end
            ST_W0: begin
                if (access_err) begin
                    state_next = ST_ERR;
                end else begin
                    if (!wr_reg) begin
                        ram_en = 1'b1;
                    end else if (!crossing) begin
                        ram_we = be0 & {8{~rst}};
                    end
                    state_next = crossing ? ST_W1 : ST_RESP;
                end
            end
            ST_W1: begin
                if (!wr_reg) begin
                    ram_en   = 1'b1;
                    ram_addr = word1_idx;
                end else begin
                    ram_we = be0 & {8{~rst}};
                end
                state_next = ST_RESP;
            end
            ST_RESP: begin
                acs.acs_ready = 1'b1;
                if (!wr_reg) begin
                    acs.acs_rdata = load_data;
                end else if (crossing) begin
                    ram_we    = be1;
                    ram_addr  = word1_idx;
                    ram_wdata = data1;
                end
                state_next = ST_IDLE;
            end
            ST_ERR: begin
                acs.acs_ready = 1'b1;
                acs.acs_err   = 1'b1;
                state_next    = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    dmem_ram #(
        .ADDR_W (DEPTH_LOG2)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_dmem_resp.sv
// Directed testbench for dmem_resp: aligned, sub-word, crossing,
// error and mid-access reset cases with hand-computed expectations.
module tb_dmem_resp;
    import dmem_resp_pkg::*;

    localparam logic [63:0] BASE = 64'h8000_0000;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    dmem_resp_if acs_if ();

    dmem_resp #(
        .DEPTH_LOG2 (12),
        .BASE_ADDR  (BASE)
    ) dut (
        .clk (clk),
        .rst (rst),
        .acs (acs_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    // Drive a request at a negedge in IDLE (cycle N), then watch for the
    // pulse. Latency k means acs_ready seen in cycle N+k; 0 means timeout.
    task automatic do_access(input string tag, input logic wr, input logic [7:0] bytes,
                             input logic [63:0] addr, input logic [63:0] wdata,
                             input int exp_lat, input logic exp_err,
                             input logic [63:0] exp_rdata);
        int          lat;
        logic [63:0] rdata;
        logic        err;
        lat   = 0;
        rdata = '0;
        err   = 1'b0;
        acs_if.acs_en    = 1'b1;
        acs_if.acs_wr    = wr;
        acs_if.acs_bytes = bytes;
        acs_if.acs_addr  = addr;
        acs_if.acs_wdata = wdata;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k == 1) begin
                // Request was latched; later input changes must be ignored.
                acs_if.acs_en    = 1'b0;
                acs_if.acs_wr    = ~wr;
                acs_if.acs_bytes = 8'h05;
                acs_if.acs_addr  = 64'h0;
                acs_if.acs_wdata = '1;
            end
            if (acs_if.acs_ready) begin
                lat   = k;
                rdata = acs_if.acs_rdata;
                err   = acs_if.acs_err;
                break;
            end
        end
        check({tag, " latency"}, 64'(lat), 64'(exp_lat));
        check({tag, " err"}, 64'(err), 64'(exp_err));
        check({tag, " rdata"}, rdata, exp_rdata);
        @(posedge clk);
        @(negedge clk);
        check({tag, " pulse end"}, 64'(acs_if.acs_ready), 64'd0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        acs_if.acs_en    = 1'b0;
        acs_if.acs_wr    = 1'b0;
        acs_if.acs_bytes = 8'h00;
        acs_if.acs_addr  = 64'h0;
        acs_if.acs_wdata = 64'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset ready", 64'(acs_if.acs_ready), 64'd0);
        check("reset err", 64'(acs_if.acs_err), 64'd0);
        check("reset rdata", acs_if.acs_rdata, 64'h0);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);

        // Aligned doubleword store and load.
        do_access("sd 0", 1'b1, SIZE_D, BASE, 64'h1122334455667788, 2, 1'b0, 64'h0);
        do_access("ld 0", 1'b0, SIZE_D, BASE, 64'h0, 2, 1'b0, 64'h1122334455667788);
        do_access("lb 3", 1'b0, SIZE_B, BASE + 3, 64'h0, 2, 1'b0, 64'h55);
        do_access("lh 6", 1'b0, SIZE_H, BASE + 6, 64'h0, 2, 1'b0, 64'h1122);

        // Crossing word store and loads.
        do_access("sw 6", 1'b1, SIZE_W, BASE + 6, 64'hDEADBEEF, 3, 1'b0, 64'h0);
        do_access("lw 6", 1'b0, SIZE_W, BASE + 6, 64'h0, 3, 1'b0, 64'hDEADBEEF);
        do_access("ld 0b", 1'b0, SIZE_D, BASE, 64'h0, 2, 1'b0, 64'hBEEF334455667788);
        do_access("lh 8", 1'b0, SIZE_H, BASE + 8, 64'h0, 2, 1'b0, 64'hDEAD);
        do_access("lb 7", 1'b0, SIZE_B, BASE + 7, 64'h0, 2, 1'b0, 64'hBE);

        // Last word of memory is usable.
        do_access("sd last", 1'b1, SIZE_D, BASE + 64'h7FF8, 64'hA5A5_0102_0304_5A5A, 2, 1'b0, 64'h0);
        do_access("ld last", 1'b0, SIZE_D, BASE + 64'h7FF8, 64'h0, 2, 1'b0, 64'hA5A5_0102_0304_5A5A);

        // Error cases: loads and stores.
        do_access("ld low", 1'b0, SIZE_D, 64'h7FFF_FFF8, 64'h0, 2, 1'b1, 64'h0);
        do_access("ld bad size", 1'b0, 8'h05, BASE, 64'h0, 2, 1'b1, 64'h0);
        do_access("ld past end", 1'b0, SIZE_D, BASE + 64'h7FFC, 64'h0, 2, 1'b1, 64'h0);
        do_access("sd low", 1'b1, SIZE_D, 64'h7FFF_FFF8, 64'hFFFF_FFFF_FFFF_FFFF, 2, 1'b1, 64'h0);
        do_access("sd bad size", 1'b1, 8'h05, BASE, 64'hFFFF_FFFF_FFFF_FFFF, 2, 1'b1, 64'h0);
        do_access("sd past end", 1'b1, SIZE_D, BASE + 64'h7FFC, 64'hFFFF_FFFF_FFFF_FFFF, 2, 1'b1, 64'h0);
        do_access("ld 0 kept", 1'b0, SIZE_D, BASE, 64'h0, 2, 1'b0, 64'hBEEF334455667788);
        do_access("ld last kept", 1'b0, SIZE_D, BASE + 64'h7FF8, 64'h0, 2, 1'b0, 64'hA5A5_0102_0304_5A5A);

        // Reset during cycle N+1 of a crossing store.
        acs_if.acs_en    = 1'b1;
        acs_if.acs_wr    = 1'b1;
        acs_if.acs_bytes = SIZE_W;
        acs_if.acs_addr  = BASE + 6;
        acs_if.acs_wdata = 64'h0102_0304;
        @(posedge clk);
        @(negedge clk);
        acs_if.acs_en = 1'b0;
        rst = 1'b1;
        check("rst n+1 ready", 64'(acs_if.acs_ready), 64'd0);
        begin
            int pulses;
            pulses = 0;
            for (int k = 0; k < 4; k++) begin
                @(posedge clk);
                @(negedge clk);
                rst = 1'b0;
                if (acs_if.acs_ready) pulses++;
            end
            check("rst no pulse", 64'(pulses), 64'd0);
        end
        do_access("lw 6 kept", 1'b0, SIZE_W, BASE + 6, 64'h0, 3, 1'b0, 64'hDEADBEEF);
        do_access("ld 0 after rst", 1'b0, SIZE_D, BASE, 64'h0, 2, 1'b0, 64'hBEEF334455667788);
        do_access("ld 8 after rst", 1'b0, SIZE_H, BASE + 8, 64'h0, 2, 1'b0, 64'hDEAD);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/dmem_resp.md
DMEM_RESP -- requirements
Module: dmem_resp

Interface
REQ-001 The block SHALL have parameter DEPTH_LOG2, default 12, setting the number of 64-bit words to 2^DEPTH_LOG2.
REQ-002 The block SHALL have parameter BASE_ADDR, default 64'h8000_0000, setting the byte address of word 0.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, with all state on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port acs_en, input, 1 bit: request valid, held until acs_ready.
REQ-006 The block SHALL have port acs_wr, input, 1 bit: 1 = store, 0 = load.
REQ-007 The block SHALL have port acs_bytes, input, 8 bits: size mask; legal values are 8'h01, 8'h03, 8'h0F and 8'hFF.
REQ-008 The block SHALL have port acs_addr, input, 64 bits: byte address, any alignment.
REQ-009 The block SHALL have port acs_wdata, input, 64 bits: store data, right-aligned.
REQ-010 The block SHALL have port acs_rdata, output, 64 bits: load data, right-aligned, with lanes beyond size zero.
REQ-011 The block SHALL have port acs_ready, output, 1 bit: one-cycle completion pulse.
REQ-012 The block SHALL have port acs_err, output, 1 bit: error flag, valid only with acs_ready.

Function
REQ-013 The block SHALL latch acs_wr, acs_bytes, acs_addr and acs_wdata in IDLE on the first cycle N with acs_en=1, and SHALL ignore input changes (including acs_en falling) until its response.
REQ-014 The state machine SHALL have the states IDLE, W0 (first word), W1 (second word, crossing only), RESP (ready pulse) and ERR.
REQ-015 The block SHALL define offset = addr[2:0] and n = size in bytes, and SHALL treat an access as crossing when offset+n > 8.
REQ-016 A non-crossing access SHALL assert acs_ready in cycle N+2.
REQ-017 A crossing access SHALL assert acs_ready in cycle N+3.
REQ-018 An error SHALL assert acs_ready with acs_err=1 in cycle N+2.
REQ-019 acs_ready SHALL stay high for exactly one cycle (RESP or ERR), after which the state SHALL return to IDLE; a new request SHALL be accepted no earlier than the cycle after the pulse.
REQ-020 A store SHALL write lanes (bytes<<offset)[7:0] of word addr with data wdata<<(8*offset); when crossing, it SHALL also write lanes bytes>>(8-offset) of the next word with wdata>>(8*(8-offset)); the write SHALL use per-byte enables with no read-modify-write.
REQ-021 A load SHALL return the n bytes starting at addr, assembled from one or two words, with acs_rdata[63:8n]=0.
REQ-022 acs_rdata SHALL be 0 whenever acs_ready=0, and also on stores and errors.
REQ-023 An error SHALL be raised for an illegal acs_bytes value, for addr<BASE_ADDR, or when any touched byte is at or above BASE_ADDR+8*2^DEPTH_LOG2; the address SHALL NOT wrap, so crossing out of the last word is an error.
REQ-024 On an error, memory SHALL NOT be written, including partially.
REQ-025 When both words of a crossing store are in range, both words SHALL be written, and a reset before the response SHALL prevent either write.

Reset
REQ-026 When rst=1 at a clock edge, the state SHALL become IDLE and acs_ready, acs_err and acs_rdata SHALL become 0.
REQ-027 When rst=1, any in-flight access SHALL be abandoned with no pulse and no further memory write.
REQ-028 Memory contents SHALL NOT be reset.
REQ-029 The first request SHALL be accepted in the cycle after rst deasserts.

Structure
REQ-030 A shared package SHALL hold the state enum, the legal size-mask constants, and the BASE_ADDR default.
REQ-031 Storage SHALL be one sub-module, dmem_ram: a single-port synchronous RAM with 64-bit data, 8 byte-enables and a 1-cycle read, with no reset.
REQ-032 The lane shift and merge logic SHALL stay in dmem_resp.

Verification
REQ-033 Store ld-size 0x1122334455667788 at 0x80000000, then load ld at the same address -> acs_ready at N+2 for each access, and acs_rdata=0x1122334455667788.
REQ-034 After REQ-033, load lb at 0x80000003 -> acs_rdata=0x0000000000000055; load lh at 0x80000006 -> 0x0000000000001122.
REQ-035 Store sw 0xDEADBEEF at 0x80000006 -> acs_ready at N+3; then lw at 0x80000006 -> 0x00000000DEADBEEF; ld at 0x80000000 -> 0xBEEF334455667788; lh at 0x80000008 -> 0xDEAD.
REQ-036 Load at 0x7FFFFFF8; acs_bytes=8'h05; ld at BASE+8*4096-4 -> each gives acs_err=1 and acs_ready at N+2 with acs_rdata=0, and a store with the same faults leaves memory unchanged.
REQ-037 Assert rst in cycle N+1 of a crossing sw to 0x80000006 -> no acs_ready, and both words unchanged; the next request is served normally.
